// File: rtl/mnvg_stream.sv
// Streaming min-sum check-node helper. A pipelined comparator tree reduces each beat to
// (min1, min2, idx). An accumulator then folds BEATS beats into one row result.
module mnvg_stream #(
  parameter int W     = 6,
  parameter int N     = 8,
  parameter int BEATS = 2,
  localparam int IDXW = ($clog2(N*BEATS) < 1) ? 1 : $clog2(N*BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N*(W-1)-1:0]   x,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [W-2:0]         min1,
  output logic [W-2:0]         min2,
  output logic [IDXW-1:0]      idx
);

  localparam int M  = W - 1;
  localparam int L  = $clog2(N);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  // A is the lower-index triple, so ties resolve toward A.
  function automatic logic [2*M+IDXW-1:0] merge3(
    input logic [M-1:0]    a1,
    input logic [M-1:0]    a2,
    input logic [IDXW-1:0] ai,
    input logic [M-1:0]    b1,
    input logic [M-1:0]    b2,
    input logic [IDXW-1:0] bi
  );
    if (a1 <= b1)
      return {a1, ((a2 <= b1) ? a2 : b1), ai};
    else
      return {b1, ((b2 <= a1) ? b2 : a1), bi};
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < L; gi++) begin : g_lvl
      localparam int CNT = N >> (gi + 1);
      logic v_in;
      logic v_reg;

      if (gi == 0) begin : g_v0
        assign v_in = in_valid;
      end else begin : g_vn
        assign v_in = g_lvl[gi-1].v_reg;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) v_reg <= 1'b0;
        else      v_reg <= v_in & ~flush;
      end

      for (gj = 0; gj < CNT; gj++) begin : g_node
        logic [M-1:0]    m1_next, m2_next;
        logic [IDXW-1:0] ix_next;
        logic [M-1:0]    m1_reg, m2_reg;
        logic [IDXW-1:0] ix_reg;

        if (gi == 0) begin : g_leaf
          logic [M-1:0] lo, hi;
          assign lo      = x[(2*gj)*M +: M];
          assign hi      = x[(2*gj+1)*M +: M];
          assign m1_next = (lo <= hi) ? lo : hi;
          assign m2_next = (lo <= hi) ? hi : lo;
          assign ix_next = (lo > hi) ? IDXW'(2*gj + 1) : IDXW'(2*gj);
        end else begin : g_merge
          assign {m1_next, m2_next, ix_next} = merge3(
            g_lvl[gi-1].g_node[2*gj].m1_reg,   g_lvl[gi-1].g_node[2*gj].m2_reg,
            g_lvl[gi-1].g_node[2*gj].ix_reg,
            g_lvl[gi-1].g_node[2*gj+1].m1_reg, g_lvl[gi-1].g_node[2*gj+1].m2_reg,
            g_lvl[gi-1].g_node[2*gj+1].ix_reg);
        end

        // Data follows the valid bit; stale data behind a cleared valid is harmless.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            m1_reg <= '0;
            m2_reg <= '0;
            ix_reg <= '0;
          end else begin
            m1_reg <= m1_next;
            m2_reg <= m2_next;
            ix_reg <= ix_next;
          end
        end
      end
    end
  endgenerate

  logic            t_v;
  logic [M-1:0]    t_m1, t_m2;
  logic [IDXW-1:0] t_ix, t_ix_g;

  assign t_v  = g_lvl[L-1].v_reg;
  assign t_m1 = g_lvl[L-1].g_node[0].m1_reg;
  assign t_m2 = g_lvl[L-1].g_node[0].m2_reg;
  assign t_ix = g_lvl[L-1].g_node[0].ix_reg;

  logic [BW-1:0]   beat_reg;
  logic [M-1:0]    acc_m1_reg, acc_m2_reg;
  logic [IDXW-1:0] acc_ix_reg;
  logic [M-1:0]    row_m1_next, row_m2_next;
  logic [IDXW-1:0] row_ix_next;
  logic [M-1:0]    mg_m1, mg_m2;
  logic [IDXW-1:0] mg_ix;
  logic            last_beat;

  assign last_beat = (beat_reg == BW'(BEATS - 1));

  always_comb begin
    t_ix_g = t_ix + (IDXW'(beat_reg) << L);
    {mg_m1, mg_m2, mg_ix} = merge3(acc_m1_reg, acc_m2_reg, acc_ix_reg, t_m1, t_m2, t_ix_g);
    row_m1_next = mg_m1;
    row_m2_next = mg_m2;
    row_ix_next = mg_ix;
    if (beat_reg == '0) begin
      row_m1_next = t_m1;
      row_m2_next = t_m2;
      row_ix_next = t_ix;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_reg   <= '0;
      acc_m1_reg <= '0;
      acc_m2_reg <= '0;
      acc_ix_reg <= '0;
      out_valid  <= 1'b0;
      min1       <= '0;
      min2       <= '0;
      idx        <= '0;
    end else if (flush) begin
      beat_reg   <= '0;
      acc_m1_reg <= '0;
      acc_m2_reg <= '0;
      acc_ix_reg <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (t_v) begin
        acc_m1_reg <= row_m1_next;
        acc_m2_reg <= row_m2_next;
        acc_ix_reg <= row_ix_next;
        if (last_beat) begin
          beat_reg  <= '0;
          out_valid <= 1'b1;
          min1      <= row_m1_next;
          min2      <= row_m2_next;
          idx       <= row_ix_next;
        end else begin
          beat_reg <= beat_reg + BW'(1);
        end
      end
    end
  end

endmodule
